hilo_seq_ctrl: RTL
==================

Name: hilo_seq_ctrl

Overview:
- Sequencer in front of the HI/LO multiply/divide register block.
- Accepts one HI/LO operation at a time from decode and latches its operands.
- Holds operands stable for a configurable latency, then pulses the write enable so HI/LO update.
- Stalls MFHI/MFLO reads and new requests while an operation is in flight; supports pipeline flush and suppresses writes on divide-by-zero.

Parameters:
- MULT_LAT, 4, cycles from acceptance edge to HI/LO update for MULT/MULTU (>=1)
- DIV_LAT, 32, cycles from acceptance edge to HI/LO update for DIV/DIVU (>=1)
- CNT_W, 6, counter width; must hold max(MULT_LAT, DIV_LAT)-1

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high reset
- req_valid  in  1  decode presents an operation
- req_op  in  3  hilo_op_t operation code
- req_a  in  32  rs operand
- req_b  in  32  rt operand
- req_ready  out  1  request accepted on this edge when req_valid && req_ready
- flush  in  1  synchronous cancel of any in-flight operation
- rd_req  in  1  decode wants MFHI/MFLO this cycle
- rd_stall  out  1  rd_req must hold; HI/LO not yet final
- busy  out  1  operation in flight
- dp_write_en  out  1  to datapath write_en
- dp_sin  out  1  to datapath sin (signed op)
- dp_op  out  2  to datapath op
- dp_in_1  out  32  latched operand A
- dp_in_2  out  32  latched operand B
- div_by_zero  out  1  one-cycle pulse on a DIV/DIVU completion with B==0

Behaviour:
- Reset (async): state IDLE, count 0, dp_in_1/dp_in_2/dp_op/dp_sin 0. dp_write_en, busy and div_by_zero are all 0.
- States: IDLE and EXEC.
- req_ready = !flush && (IDLE || (EXEC && count==0)), so back-to-back acceptance in the final cycle is allowed.
- On acceptance (edge T), latch req_a and req_b into dp_in_1/dp_in_2, then map the op:
  - MTHI -> dp_op 00; MTLO -> dp_op 01 (both count load 0).
  - MULT/MULTU -> dp_op 10, count load MULT_LAT-1.
  - DIV/DIVU -> dp_op 11, count load DIV_LAT-1.
  - dp_sin = 1 for MULT and DIV only.
  - Set zero_div = (op is DIV/DIVU && req_b==0). Go to EXEC.
- Unused op codes 6 and 7 are accepted and discarded: state is unchanged, nothing is latched.
- EXEC:
  - count decrements each cycle while nonzero.
  - When count==0: dp_write_en = !flush && !zero_div, and div_by_zero = zero_div && !flush.
  - Next state is EXEC if a new request is accepted that cycle, else IDLE.
- Latency: HI/LO hold the new value after edge T+LAT, where LAT is 1 for MT ops. Operand outputs stay stable throughout EXEC.
- busy = (state==EXEC).
- rd_stall = rd_req && busy, including the final cycle. The first unstalled read sees the updated HI/LO.
- Flush asserted in EXEC: dp_write_en forced 0 that cycle, next state IDLE, no acceptance that cycle. Flush in IDLE drops a simultaneous request.
- dp_write_en is combinational from state/count/flush/zero_div, one pulse per operation, never high in IDLE.
- Reset mid-operation: immediate return to IDLE and the write is lost; the datapath's own reset clears HI/LO.

Decomposition:
- Package hilo_pkg holds:
  - hilo_op_t enum: MTHI=0, MTLO=1, MULT=2, MULTU=3, DIV=4, DIVU=5.
  - Datapath op constants DP_MTHI=2'b00, DP_MTLO=2'b01, DP_MUL=2'b10, DP_DIV=2'b11.
  - state_t {IDLE, EXEC}.
- No sub-module; the down-counter is inline. Top-level integration instantiates this block alongside the existing HI/LO register block.

Test Plan:
- Reset mid-EXEC of DIV -> busy=0 and dp_write_en=0 immediately; HI/LO unchanged after reset release.
- MTHI a=0x12345678 accepted at edge T -> dp_write_en high for exactly one cycle, HI=0x12345678 after edge T+1, busy for 1 cycle.
- MULT a=0xFFFFFFFE b=3 (MULT_LAT=4) -> dp_sin=1, dp_op=10; write pulse in cycle T+4; HI=0xFFFFFFFF, LO=0xFFFFFFFA; rd_req stalled in cycles T+1..T+4.
- DIVU a=100 b=7 (DIV_LAT=32), then DIV issued with req_valid held -> req_ready=0 until the final cycle, then accepted back-to-back; first result LO=14, HI=2.
- DIV b=0 -> no write pulse, div_by_zero pulses once in the final cycle, prior HI/LO preserved.
- MULTU flushed at cycle T+2 -> no write, state IDLE next cycle; a request presented with flush is dropped, and the same request is accepted the cycle after.

Source files
------------

// File: rtl/hilo_pkg.sv
// rtl/hilo_pkg.sv - shared types and op mapping for the HI/LO sequencer
package hilo_pkg;

   typedef enum logic [2:0] {
      MTHI  = 3'd0,
      MTLO  = 3'd1,
      MULT  = 3'd2,
      MULTU = 3'd3,
      DIV   = 3'd4,
      DIVU  = 3'd5
   } hilo_op_t;

   localparam logic [1:0] DP_MTHI = 2'b00;
   localparam logic [1:0] DP_MTLO = 2'b01;
   localparam logic [1:0] DP_MUL  = 2'b10;
   localparam logic [1:0] DP_DIV  = 2'b11;

   typedef enum logic {
      IDLE = 1'b0,
      EXEC = 1'b1
   } state_t;

   // Codes 6 and 7 have no datapath meaning and are swallowed on acceptance.
   function automatic logic op_known(input logic [2:0] op);
      return op <= 3'd5;
   endfunction

   function automatic logic [1:0] dp_op_of(input logic [2:0] op);
      logic [1:0] r;
      case (op)
         MTHI:        r = DP_MTHI;
         MTLO:        r = DP_MTLO;
         MULT, MULTU: r = DP_MUL;
         default:     r = DP_DIV;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/hilo_seq_ctrl.sv
// rtl/hilo_seq_ctrl.sv - one-at-a-time HI/LO op sequencer with latency counter
// Latches operands on acceptance and pulses dp_write_en when the counter reaches zero.
module hilo_seq_ctrl
   import hilo_pkg::*;
#(
   parameter int MULT_LAT = 4,
   parameter int DIV_LAT  = 32,
   parameter int CNT_W    = 6
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   input  logic [2:0]  req_op,
   input  logic [31:0] req_a,
   input  logic [31:0] req_b,
   output logic        req_ready,
   input  logic        flush,
   input  logic        rd_req,
   output logic        rd_stall,
   output logic        busy,
   output logic        dp_write_en,
   output logic        dp_sin,
   output logic [1:0]  dp_op,
   output logic [31:0] dp_in_1,
   output logic [31:0] dp_in_2,
   output logic        div_by_zero
);

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   count_q, count_d;
   logic               zero_div_q, zero_div_d;
   logic [31:0]        dp_in_1_q, dp_in_1_d;
   logic [31:0]        dp_in_2_q, dp_in_2_d;
   logic [1:0]         dp_op_q, dp_op_d;
   logic               dp_sin_q, dp_sin_d;
   logic               final_cyc;
   logic               start;
   logic [1:0]         new_dp_op;

   assign final_cyc = (state_q == EXEC) && (count_q == '0);
   assign req_ready = !flush && ((state_q == IDLE) || (count_q == '0));
   assign start     = req_valid && req_ready && op_known(req_op);
   assign new_dp_op = dp_op_of(req_op);

   always_comb begin
      state_d    = state_q;
      count_d    = count_q;
      zero_div_d = zero_div_q;
      dp_in_1_d  = dp_in_1_q;
      dp_in_2_d  = dp_in_2_q;
      dp_op_d    = dp_op_q;
      dp_sin_d   = dp_sin_q;

      if (state_q == EXEC) begin
         if (flush || final_cyc) begin
            state_d = IDLE;
            count_d = '0;
         end else begin
            count_d = count_q - CNT_W'(1);
         end
      end

      // A start in the final cycle overrides the return to IDLE above.
      if (start) begin
         state_d    = EXEC;
         dp_in_1_d  = req_a;
         dp_in_2_d  = req_b;
         dp_op_d    = new_dp_op;
         dp_sin_d   = (req_op == MULT) || (req_op == DIV);
         zero_div_d = (new_dp_op == DP_DIV) && (req_b == 32'd0);
         if (new_dp_op == DP_MUL) begin
            count_d = CNT_W'(MULT_LAT - 1);
         end else if (new_dp_op == DP_DIV) begin
            count_d = CNT_W'(DIV_LAT - 1);
         end else begin
            count_d = '0;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         count_q    <= '0;
         zero_div_q <= 1'b0;
         dp_in_1_q  <= '0;
         dp_in_2_q  <= '0;
         dp_op_q    <= DP_MTHI;
         dp_sin_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         count_q    <= count_d;
         zero_div_q <= zero_div_d;
         dp_in_1_q  <= dp_in_1_d;
         dp_in_2_q  <= dp_in_2_d;
         dp_op_q    <= dp_op_d;
         dp_sin_q   <= dp_sin_d;
      end
   end

   assign dp_write_en = final_cyc && !flush && !zero_div_q;
   assign div_by_zero = final_cyc && zero_div_q && !flush;
   assign busy        = (state_q == EXEC);
   assign rd_stall    = rd_req && busy;
   assign dp_in_1     = dp_in_1_q;
   assign dp_in_2     = dp_in_2_q;
   assign dp_op       = dp_op_q;
   assign dp_sin      = dp_sin_q;

endmodule
